dbus_responder: RTL and testbench
=================================

# dbus_responder

Memory-side responder for the data bus (`dbus_req_t` / `dbus_resp_t`) that the pipeline's memory stage drives. It accepts one load/store at a time from the initiator, models a fixed access latency, and returns read data through `dresp`. Storage is an internal 64-bit word array. It serves as the simulation/FPGA data memory behind the core and as the reference responder for memory-stage verification.

## Interface
- `MEM_WORDS`, 1024: number of 64-bit words in the array; index width is `$clog2(MEM_WORDS)`.
- `BASE_ADDR`, 64'h8000_0000: byte address of word 0.
- `LATENCY`, 2: wait cycles between accept and response; legal range 0–15.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low; 0 at a rising edge resets the FSM.
- `dreq`  in  `dbus_req_t`  fields: `valid`, `addr[63:0]`, `size`, `strobe[7:0]`, `data[63:0]`. A store has `strobe != 0`; a load has `strobe == 0`.
- `dresp`  out  `dbus_resp_t`  fields: `addr_ok`, `data_ok`, `data[63:0]`.
- `err`  out  1  one-cycle pulse, coincident with `data_ok`, when the transaction's address was out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, `dreq.valid=1`:
  - Drive `addr_ok=1` combinationally in that cycle (accept).
  - Latch `addr`, `strobe`, and `data`.
  - Load counter with `LATENCY`.
  - Go to WAIT, or straight to RESP if `LATENCY=0`.
- WAIT: decrement counter each cycle; go to RESP when it reaches 1.
- RESP:
  - `data_ok=1` for exactly one cycle.
  - `dresp.data` = the full 64-bit word at the latched index, read before any write in that cycle.
  - A store commits in the same RESP cycle: byte `i` is written iff `strobe[i]`.
  - Next state is IDLE.
- Index is `(addr - BASE_ADDR) >> 3`. `addr[2:0]` and `size` are ignored; byte extraction and sign extension belong to the memory stage. Strobe positions are already lane-aligned.
- Out of range: `addr < BASE_ADDR` or index ≥ `MEM_WORDS`.
  - Store is dropped.
  - Load returns 64'h0.
  - `err=1` with `data_ok`.
- Outside RESP, `dresp.data` is 0. `addr_ok` is 0 in WAIT and RESP, so a request still held high during RESP is not re-accepted.
- After acceptance, the responder ignores `dreq`. If `valid` drops mid-transaction (protocol violation), the transaction still completes with the latched values.
- Memory contents are not cleared by reset. The bench initialises them by backdoor or through stores.

## Timing
- Reset (`reset=0` at an edge):
  - State becomes IDLE and the counter clears.
  - `addr_ok`, `data_ok`, `err`, and `dresp.data` read 0 in the following cycle.
  - A store pending in WAIT is discarded and the array is unchanged.
  - A reset edge during RESP overrides that cycle's write.
- If the request is accepted in cycle T, `data_ok` occurs in cycle T+1+`LATENCY`.
- Throughput: if the initiator holds the next request valid, it is accepted in cycle T+2+`LATENCY`. The steady-state period is `LATENCY`+2 cycles per access.
- A read of the same word in a following transaction returns data written in an earlier RESP cycle.
- `addr_ok` and `data_ok` are never asserted in the same cycle.

## Test plan
- Write then read, `LATENCY=2`:
  - Store `addr=BASE+8`, `strobe=8'hFF`, `data=64'h1122334455667788`: `addr_ok` at T, `data_ok` at T+3.
  - Load `BASE+8`: `data=64'h1122334455667788`.
- Partial strobe:
  - Preload word 0 with 64'hFFFF_FFFF_FFFF_FFFF.
  - Store `addr=BASE+4`, `strobe=8'hF0`, `data=64'h0000_0001_0000_0000`.
  - Load `BASE`: `data=64'h0000_0001_FFFF_FFFF`.
- Out of range:
  - Store to `BASE+8*MEM_WORDS`: `data_ok=1`, `err=1`, no array change.
  - Load from `BASE-8`: `data=0`, `err=1`.
- Back-to-back, `LATENCY=0`:
  - `valid` held continuously over three loads: `addr_ok` at cycles 0, 2, 4; `data_ok` at 1, 3, 5.
  - `addr_ok` is never high while `data_ok` is high.
- Reset mid-operation:
  - Store accepted, then `reset=0` one cycle later: no `data_ok`, all outputs 0 next cycle.
  - A subsequent load shows the old word contents.
- Valid drop:
  - Accept a load, deassert `valid` in WAIT: `data_ok` still at T+1+`LATENCY`, with correct data.

Source files
------------

// File: rtl/dbus_responder.sv
// dbus_responder: single-outstanding data-bus memory responder with a fixed access latency.
// The backing store is a 64-bit word array; byte strobes select which lanes a store updates.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int         IW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          in_range_q, in_range_d;
  logic [7:0]    strobe_q, strobe_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          data_ok_q, data_ok_d;
  logic          err_q, err_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          accept_s;

  logic [63:0]   req_off_s;
  logic [63:0]   req_word_s;
  logic          req_in_range_s;
  logic [IW-1:0] req_idx_s;
  logic [2:0]    unused_size_s;

  logic [63:0]   mem_q [MEM_WORDS];

  assign unused_size_s = dreq.size;

  // Address decode of the incoming request: word index and range check.
  always_comb begin
    req_off_s      = dreq.addr - BASE_ADDR;
    req_word_s     = req_off_s >> 3'd3;
    req_in_range_s = (dreq.addr >= BASE_ADDR) && (req_word_s < 64'(MEM_WORDS));
    req_idx_s      = req_word_s[IW-1:0];
  end

  // Next-state logic; response data is fetched while entering RESP so it
  // holds the word as it was before that cycle's store commits.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    strobe_d   = strobe_q;
    wdata_d    = wdata_q;
    data_ok_d  = 1'b0;
    err_d      = 1'b0;
    rdata_d    = 64'h0;
    accept_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          accept_s   = 1'b1;
          idx_d      = req_idx_s;
          in_range_d = req_in_range_s;
          strobe_d   = dreq.strobe;
          wdata_d    = dreq.data;
          cnt_d      = LAT;
          if (LAT == 4'd0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (state_d == RESP) begin
      data_ok_d = 1'b1;
      err_d     = ~in_range_d;
      if (in_range_d) begin
        rdata_d = mem_q[idx_d];
      end else begin
        rdata_d = 64'h0;
      end
    end else begin
      data_ok_d = 1'b0;
      err_d     = 1'b0;
      rdata_d   = 64'h0;
    end
  end

  // FSM and registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      strobe_q   <= 8'h00;
      wdata_q    <= 64'h0;
      data_ok_q  <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 64'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      strobe_q   <= strobe_d;
      wdata_q    <= wdata_d;
      data_ok_q  <= data_ok_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Store commit in the RESP cycle; a reset edge in that cycle suppresses it.
  always_ff @(posedge clk) begin
    if (reset && (state_q == RESP) && in_range_q) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign dresp = '{addr_ok: accept_s, data_ok: data_ok_q, data: rdata_q};
  assign err   = err_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder: directed scenarios plus randomized
// traffic checked against a word-level memory model.
module tb_dbus_responder;
  import dbus_pkg::*;

  localparam int          MW   = 1024;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          LAT  = 2;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq, dreq0;
  dbus_resp_t dresp, dresp0;
  logic       err, err0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] model [int];

  always #5 clk = ~clk;

  dbus_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .err(err));

  dbus_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .dreq(dreq0), .dresp(dresp0), .err(err0));

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * MW));
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) / 64'd8);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One transaction on the LATENCY=2 instance; lat counts cycles from accept to data_ok.
  task automatic run_txn(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                         input bit hold_in_wait, output logic [63:0] rd, output logic e,
                         output int lat, output bit reacc);
    int c;
    reacc = 1'b0;
    @(negedge clk);
    dreq = '{valid: 1'b1, addr: a, size: 3'd3, strobe: s, data: d};
    #1;
    c = 0;
    while (dresp.addr_ok !== 1'b1 && c < 20) begin
      @(negedge clk); #1; c++;
    end
    if (c >= 20) begin
      lat = -1; rd = 64'hx; e = 1'bx; dreq.valid = 1'b0;
      return;
    end
    lat = 0;
    do begin
      @(negedge clk);
      if (hold_in_wait && lat < LAT)
        dreq = '{valid: 1'b1, addr: BASE, size: 3'd3, strobe: 8'hFF, data: 64'hDEAD_BEEF_DEAD_BEEF};
      else
        dreq.valid = 1'b0;
      #1;
      lat++;
      if (dresp.addr_ok === 1'b1 && dresp.data_ok !== 1'b1) reacc = 1'b1;
    end while (dresp.data_ok !== 1'b1 && lat < 20);
    rd = dresp.data;
    e  = err;
    dreq.valid = 1'b0;
  endtask

  task automatic test_reset();
    dreq  = '0;
    dreq0 = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (dresp.addr_ok !== 1'b0) begin tests_failed++; $display("FAIL rst_addr_ok: got %b expected 0", dresp.addr_ok); end
    tests_run++; if (dresp.data_ok !== 1'b0) begin tests_failed++; $display("FAIL rst_data_ok: got %b expected 0", dresp.data_ok); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %b expected 0", err); end
    tests_run++; if (dresp.data !== 64'h0) begin tests_failed++; $display("FAIL rst_data: got %h expected 0", dresp.data); end
    tests_run++; if (dresp0.data_ok !== 1'b0 || err0 !== 1'b0 || dresp0.data !== 64'h0) begin
      tests_failed++; $display("FAIL rst_lat0: got data_ok=%b err=%b data=%h expected all 0", dresp0.data_ok, err0, dresp0.data); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    logic [63:0] rd; logic e; int lat; bit ra;
    run_txn(BASE + 64'd8, 8'hFF, 64'h1122334455667788, 1'b0, rd, e, lat, ra);
    model[1] = 64'h1122334455667788;
    tests_run++; if (lat !== LAT + 1) begin tests_failed++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT + 1); end
    tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL wr_err: got %b expected 0", e); end
    run_txn(BASE + 64'd8, 8'h00, 64'h0, 1'b0, rd, e, lat, ra);
    tests_run++; if (rd !== 64'h1122334455667788) begin tests_failed++; $display("FAIL rd_data: got %h expected 1122334455667788", rd); end
    tests_run++; if (lat !== LAT + 1) begin tests_failed++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT + 1); end
  endtask

  task automatic test_partial_strobe();
    logic [63:0] rd; logic e; int lat; bit ra;
    run_txn(BASE, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rd, e, lat, ra);
    model[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_txn(BASE + 64'd4, 8'hF0, 64'h0000_0001_0000_0000, 1'b0, rd, e, lat, ra);
    tests_run++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("FAIL partial_old_word: got %h expected ffffffffffffffff", rd); end
    model[0] = merge(model[0], 64'h0000_0001_0000_0000, 8'hF0);
    run_txn(BASE, 8'h00, 64'h0, 1'b0, rd, e, lat, ra);
    tests_run++; if (rd !== 64'h0000_0001_FFFF_FFFF) begin tests_failed++; $display("FAIL partial_merge: got %h expected 00000001ffffffff", rd); end
  endtask

  task automatic test_out_of_range();
    logic [63:0] rd; logic e; int lat; bit ra;
    run_txn(BASE + 64'(8 * MW), 8'hFF, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, rd, e, lat, ra);
    tests_run++; if (e !== 1'b1) begin tests_failed++; $display("FAIL oor_store_err: got %b expected 1", e); end
    tests_run++; if (lat !== LAT + 1) begin tests_failed++; $display("FAIL oor_store_latency: got %0d expected %0d", lat, LAT + 1); end
    tests_run++; if (rd !== 64'h0) begin tests_failed++; $display("FAIL oor_store_data: got %h expected 0", rd); end
    run_txn(BASE, 8'h00, 64'h0, 1'b0, rd, e, lat, ra);
    tests_run++; if (rd !== model[0]) begin tests_failed++; $display("FAIL oor_no_alias: got %h expected %h", rd, model[0]); end
    run_txn(BASE - 64'd8, 8'h00, 64'h0, 1'b0, rd, e, lat, ra);
    tests_run++; if (rd !== 64'h0 || e !== 1'b1) begin tests_failed++; $display("FAIL oor_load: got data=%h err=%b expected data=0 err=1", rd, e); end
    run_txn(BASE + 64'(8 * (MW - 1)), 8'hFF, 64'h0BAD_F00D_1234_5678, 1'b0, rd, e, lat, ra);
    model[MW - 1] = 64'h0BAD_F00D_1234_5678;
    run_txn(BASE + 64'(8 * (MW - 1)), 8'h00, 64'h0, 1'b0, rd, e, lat, ra);
    tests_run++; if (rd !== 64'h0BAD_F00D_1234_5678 || e !== 1'b0) begin
      tests_failed++; $display("FAIL last_word: got data=%h err=%b expected data=0badf00d12345678 err=0", rd, e); end
  endtask

  task automatic test_valid_drop();
    logic [63:0] rd; logic e; int lat; bit ra;
    run_txn(BASE + 64'd8, 8'h00, 64'h0, 1'b1, rd, e, lat, ra);
    tests_run++; if (lat !== LAT + 1) begin tests_failed++; $display("FAIL drop_latency: got %0d expected %0d", lat, LAT + 1); end
    tests_run++; if (rd !== model[1]) begin tests_failed++; $display("FAIL drop_data: got %h expected %h", rd, model[1]); end
    tests_run++; if (ra !== 1'b0) begin tests_failed++; $display("FAIL drop_reaccept: got %b expected 0", ra); end
    run_txn(BASE, 8'h00, 64'h0, 1'b0, rd, e, lat, ra);
    tests_run++; if (rd !== model[0]) begin tests_failed++; $display("FAIL drop_ignored_req: got %h expected %h", rd, model[0]); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic e; int lat; bit ra; bit seen_ok;
    @(negedge clk);
    dreq = '{valid: 1'b1, addr: BASE + 64'd8, size: 3'd3, strobe: 8'hFF, data: 64'h7777_6666_5555_4444};
    #1;
    tests_run++; if (dresp.addr_ok !== 1'b1) begin tests_failed++; $display("FAIL rmid_accept: got %b expected 1", dresp.addr_ok); end
    @(negedge clk);
    dreq.valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++; if ({dresp.addr_ok, dresp.data_ok, err} !== 3'b000 || dresp.data !== 64'h0) begin
      tests_failed++; $display("FAIL rmid_outputs: got addr_ok=%b data_ok=%b err=%b data=%h expected all 0",
                               dresp.addr_ok, dresp.data_ok, err, dresp.data); end
    seen_ok = 1'b0;
    repeat (5) begin
      @(negedge clk); #1;
      if (dresp.data_ok === 1'b1) seen_ok = 1'b1;
    end
    tests_run++; if (seen_ok !== 1'b0) begin tests_failed++; $display("FAIL rmid_no_data_ok: got %b expected 0", seen_ok); end
    run_txn(BASE + 64'd8, 8'h00, 64'h0, 1'b0, rd, e, lat, ra);
    tests_run++; if (rd !== model[1]) begin tests_failed++; $display("FAIL rmid_old_word: got %h expected %h", rd, model[1]); end
  endtask

  task automatic test_random();
    logic [63:0] rd, a, d, exp_rd; logic [7:0] s; logic e, exp_e; int lat; bit ra, hold;
    int pool [10];
    for (int i = 0; i < 8; i++) pool[i] = i;
    pool[8] = MW - 2;
    pool[9] = MW - 1;
    for (int i = 0; i < 10; i++) begin
      d = {$urandom, $urandom};
      run_txn(BASE + 64'(8 * pool[i]), 8'hFF, d, 1'b0, rd, e, lat, ra);
      model[pool[i]] = d;
    end
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        if ($urandom_range(0, 1) == 0) a = BASE - 64'(8 * (1 + $urandom_range(0, 100)));
        else a = BASE + 64'(8 * MW) + 64'(8 * $urandom_range(0, 100));
      end else begin
        a = BASE + 64'(8 * pool[$urandom_range(0, 9)]);
      end
      a[2:0] = 3'($urandom_range(0, 7));
      s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      d = {$urandom, $urandom};
      hold = ($urandom_range(0, 3) == 0);
      if (in_rng(a)) begin
        exp_rd = model[widx(a)];
        exp_e  = 1'b0;
        model[widx(a)] = merge(model[widx(a)], d, s);
      end else begin
        exp_rd = 64'h0;
        exp_e  = 1'b1;
      end
      run_txn(a, s, d, hold, rd, e, lat, ra);
      tests_run++; if (rd !== exp_rd) begin tests_failed++; $display("FAIL rand_data[%0d]: addr=%h got %h expected %h", n, a, rd, exp_rd); end
      tests_run++; if (e !== exp_e) begin tests_failed++; $display("FAIL rand_err[%0d]: addr=%h got %b expected %b", n, a, e, exp_e); end
      tests_run++; if (lat !== LAT + 1 || ra !== 1'b0) begin
        tests_failed++; $display("FAIL rand_timing[%0d]: got latency=%0d reaccept=%b expected %0d/0", n, lat, ra, LAT + 1); end
    end
  endtask

  task automatic test_back_to_back();
    dbus_req_t   reqs [6];
    logic [63:0] d [3];
    int k;
    bit ao, dk, exp_ao, exp_dk;
    for (int j = 0; j < 3; j++) begin
      d[j] = {$urandom, $urandom};
      reqs[j]     = '{valid: 1'b1, addr: BASE + 64'(8 * (10 + j)), size: 3'd3, strobe: 8'hFF, data: d[j]};
      reqs[3 + j] = '{valid: 1'b1, addr: BASE + 64'(8 * (10 + j)), size: 3'd3, strobe: 8'h00, data: 64'h0};
    end
    k = 0;
    @(negedge clk);
    dreq0 = reqs[0];
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      ao = dresp0.addr_ok;
      dk = dresp0.data_ok;
      exp_ao = (cyc % 2 == 0);
      exp_dk = (cyc % 2 == 1);
      tests_run++; if (ao !== exp_ao) begin tests_failed++; $display("FAIL b2b_addr_ok[%0d]: got %b expected %b", cyc, ao, exp_ao); end
      tests_run++; if (dk !== exp_dk) begin tests_failed++; $display("FAIL b2b_data_ok[%0d]: got %b expected %b", cyc, dk, exp_dk); end
      tests_run++; if ((ao & dk) !== 1'b0) begin tests_failed++; $display("FAIL b2b_overlap[%0d]: got %b expected 0", cyc, ao & dk); end
      if (dk && cyc / 2 >= 3) begin
        tests_run++; if (dresp0.data !== d[cyc / 2 - 3]) begin
          tests_failed++; $display("FAIL b2b_load_data[%0d]: got %h expected %h", cyc, dresp0.data, d[cyc / 2 - 3]); end
      end
      if (ao) k++;
      @(negedge clk);
      if (k < 6) dreq0 = reqs[k];
      else dreq0 = '0;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_out_of_range();
    test_valid_drop();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
